// File: rtl/fc_lcc_tb_cmd_issuer.sv
// fc_lcc_tb_cmd_issuer
//   Testbench-side initiator of the tb-service command interface.
//
//   The block watches firmware writes for the command mailbox address and
//   queues each non-zero command byte in a small FIFO. It then replays the
//   queued commands as one-cycle strobes. After each command it waits a
//   short gap, and after the FC/LCC reset command it waits a longer hold-off.
//
// Ports
//   clk, cptra_rst_b            : clock and async active-low reset
//   wr_valid/wr_addr/wr_data    : sniffed register write (command = data[7:0])
//   clear_overflow              : clears overflow_sticky
//   tb_service_cmd_valid/_cmd   : registered one-cycle command strobe + code
//   fifo_full, busy             : combinational status from FIFO/FSM state
//   overflow_sticky             : a command was dropped on a full queue
//   issued_count                : commands issued (wraps)
`timescale 1ns/1ps
module fc_lcc_tb_cmd_issuer #(
  parameter logic [31:0] CMD_ADDR      = 32'h0000_0000,
  parameter int          FIFO_DEPTH    = 4,
  parameter int          MIN_GAP       = 2,
  parameter logic [7:0]  RESET_CMD     = 8'hF0,
  parameter int          RESET_HOLDOFF = 12
) (
  input  logic        clk,
  input  logic        cptra_rst_b,
  input  logic        wr_valid,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic        clear_overflow,
  output logic        tb_service_cmd_valid,
  output logic [7:0]  tb_service_cmd,
  output logic        fifo_full,
  output logic        overflow_sticky,
  output logic        busy,
  output logic [15:0] issued_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(RESET_HOLDOFF + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, HOLDOFF} state_t;

  // Reset assertion is asynchronous. Release is re-timed to clk so that
  // every flop leaves reset on the same edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge cptra_rst_b)
    if (!cptra_rst_b) rst_sync <= '0;
    else              rst_sync <= {rst_sync[0], 1'b1};

  assign rst_n = rst_sync[1];

  // Only the low byte carries a command. The upper bits are don't-care.
  logic unused_data;
  assign unused_data = ^wr_data[31:8];

  // ---------------- command FIFO ----------------
  // The pointers carry one extra wrap bit, so full and empty can be told
  // apart without a separate count.
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full, push_req, push_ok, pop, drop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  assign push_req = wr_valid && (wr_addr == CMD_ADDR) && (wr_data[7:0] != 8'h00);
  // A pop in the same cycle frees a slot, so a push into a full queue is
  // still accepted then.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && !push_ok;

  always_ff @(posedge clk)
    if (push_ok) mem[wptr[AW-1:0]] <= wr_data[7:0];

  // ---------------- issue FSM ----------------
  state_t          state, nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            valid_nxt, ovf_nxt;
  logic [7:0]      cmd_nxt;
  logic [15:0]     count_nxt;

  assign pop = (state == IDLE) && !empty;

  // State register, plus the registered outputs and the FIFO pointers.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state                <= IDLE;
      cnt                  <= '0;
      wptr                 <= '0;
      rptr                 <= '0;
      tb_service_cmd_valid <= 1'b0;
      tb_service_cmd       <= 8'h00;
      overflow_sticky      <= 1'b0;
      issued_count         <= 16'h0000;
    end else begin
      state                <= nxt;
      cnt                  <= cnt_nxt;
      if (push_ok) wptr    <= wptr + 1'b1;
      if (pop)     rptr    <= rptr + 1'b1;
      tb_service_cmd_valid <= valid_nxt;
      tb_service_cmd       <= cmd_nxt;
      overflow_sticky      <= ovf_nxt;
      issued_count         <= count_nxt;
    end

  // Next state. In ISSUE, tb_service_cmd still holds the code being issued.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    case (state)
      IDLE:  if (!empty) nxt = ISSUE;
      ISSUE: if (tb_service_cmd == RESET_CMD) begin
               nxt     = HOLDOFF;
               cnt_nxt = CW'(RESET_HOLDOFF);
             end else begin
               nxt     = GAP;
               cnt_nxt = CW'(MIN_GAP);
             end
      GAP, HOLDOFF:
             if (cnt == CW'(1)) nxt = IDLE;
             else               cnt_nxt = cnt - 1'b1;
      default: nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    valid_nxt = (nxt == ISSUE);
    cmd_nxt   = pop ? mem[rptr[AW-1:0]] : tb_service_cmd;
    count_nxt = (state == ISSUE) ? issued_count + 16'd1 : issued_count;
    // When a drop and a clear arrive in the same cycle, the set wins.
    ovf_nxt   = drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow_sticky);
  end

  assign fifo_full = full;
  assign busy      = !empty || (state != IDLE);

endmodule

// File: tb/tb_fc_lcc_tb_cmd_issuer.sv
`timescale 1ns/1ps
module tb_fc_lcc_tb_cmd_issuer;
  localparam logic [31:0] CMD_ADDR      = 32'h0000_0000;
  localparam int          FIFO_DEPTH    = 4;
  localparam int          MIN_GAP       = 2;
  localparam logic [7:0]  RESET_CMD     = 8'hF0;
  localparam int          RESET_HOLDOFF = 12;

  logic        clk = 1'b0, cptra_rst_b = 1'b0, wr_valid = 1'b0, clear_overflow = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic        tb_service_cmd_valid, fifo_full, overflow_sticky, busy;
  logic [7:0]  tb_service_cmd;
  logic [15:0] issued_count;

  fc_lcc_tb_cmd_issuer #(
    .CMD_ADDR(CMD_ADDR), .FIFO_DEPTH(FIFO_DEPTH), .MIN_GAP(MIN_GAP),
    .RESET_CMD(RESET_CMD), .RESET_HOLDOFF(RESET_HOLDOFF)
  ) dut (
    .clk(clk), .cptra_rst_b(cptra_rst_b), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_data(wr_data), .clear_overflow(clear_overflow),
    .tb_service_cmd_valid(tb_service_cmd_valid), .tb_service_cmd(tb_service_cmd),
    .fifo_full(fifo_full), .overflow_sticky(overflow_sticky), .busy(busy),
    .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model. It is time-based: the queue holds pending codes, and
  // each issued code blocks the next pop until a fixed number of cycles has
  // passed (MIN_GAP+2 after a normal command, RESET_HOLDOFF+2 after a reset).
  logic [7:0]  q[$];
  int          m_cyc, m_ready, m_strobe;
  logic [7:0]  m_cmd;
  logic [15:0] m_count;
  bit          m_ovf;
  int          s_cyc[$];
  logic [7:0]  s_cmd[$];
  bit          saw_full;

  task automatic model_reset();
    q.delete();
    m_ready = 0; m_strobe = -1; m_cmd = 8'h00; m_count = 16'h0; m_ovf = 1'b0;
  endtask

  task automatic observe();
    chk("strobe",   tb_service_cmd_valid, m_strobe == m_cyc);
    chk("cmd",      tb_service_cmd, m_cmd);
    chk("count",    issued_count, m_count);
    chk("full",     fifo_full, q.size() == FIFO_DEPTH);
    chk("busy",     busy, (q.size() > 0) || (m_cyc < m_ready));
    chk("overflow", overflow_sticky, m_ovf);
    if (tb_service_cmd_valid) begin s_cyc.push_back(m_cyc); s_cmd.push_back(tb_service_cmd); end
    if (fifo_full) saw_full = 1'b1;
  endtask

  task automatic drive_adv(input bit v, input logic [31:0] a, input logic [31:0] d, input bit c);
    bit req, pop, acc;
    logic [7:0] x;
    wr_valid = v; wr_addr = a; wr_data = d; clear_overflow = c;
    req = v && (a == CMD_ADDR) && (d[7:0] != 8'h00);
    pop = (m_cyc >= m_ready) && (q.size() > 0);
    if (m_strobe == m_cyc) m_count++;
    if (pop) begin
      x = q.pop_front();
      m_cmd = x;
      m_strobe = m_cyc + 1;
      m_ready = m_cyc + ((x == RESET_CMD) ? RESET_HOLDOFF + 2 : MIN_GAP + 2);
    end
    acc = req && (q.size() < FIFO_DEPTH);
    if (acc) q.push_back(d[7:0]);
    if (req && !acc) m_ovf = 1'b1;
    else if (c)      m_ovf = 1'b0;
    m_cyc++;
  endtask

  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d, input bit c);
    @(posedge clk); #1;
    observe();
    drive_adv(v, a, d, c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0);
  endtask

  typedef struct {
    bit v; logic [31:0] a; logic [31:0] d;
    bit ev; logic [7:0] ecmd; bit ebusy; logic [15:0] ecnt;
  } vec_t;
  vec_t tbl[10];

  initial begin
    // Expected values are what is observed in each cycle. The inputs of a
    // row are driven in that same cycle.
    tbl[0] = '{1, CMD_ADDR,     32'h0000_0012, 0, 8'h00, 0, 16'd0};
    tbl[1] = '{0, '0,           '0,            0, 8'h00, 1, 16'd0};
    tbl[2] = '{0, '0,           '0,            1, 8'h12, 1, 16'd0};
    tbl[3] = '{0, '0,           '0,            0, 8'h12, 1, 16'd1};
    tbl[4] = '{0, '0,           '0,            0, 8'h12, 1, 16'd1};
    tbl[5] = '{1, CMD_ADDR + 4, 32'h0000_0055, 0, 8'h12, 0, 16'd1};
    tbl[6] = '{1, CMD_ADDR,     32'h0000_0000, 0, 8'h12, 0, 16'd1};
    tbl[7] = '{1, CMD_ADDR,     32'hABCD_EF00, 0, 8'h12, 0, 16'd1};
    tbl[8] = '{0, '0,           '0,            0, 8'h12, 0, 16'd1};
    tbl[9] = '{0, '0,           '0,            0, 8'h12, 0, 16'd1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobe", tb_service_cmd_valid, 0); chk("rst_cmd", tb_service_cmd, 0);
    chk("rst_count", issued_count, 0);          chk("rst_full", fifo_full, 0);
    chk("rst_busy", busy, 0);                   chk("rst_ovf", overflow_sticky, 0);
    @(negedge clk); cptra_rst_b = 1'b1;
    repeat (3) @(posedge clk);
    model_reset(); m_cyc = 0;

    // Directed table: single-command latency, a wrong address, no-op codes.
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_strobe", k), tb_service_cmd_valid, tbl[k].ev);
      chk($sformatf("tbl%0d_cmd", k),    tb_service_cmd, tbl[k].ecmd);
      chk($sformatf("tbl%0d_busy", k),   busy, tbl[k].ebusy);
      chk($sformatf("tbl%0d_count", k),  issued_count, tbl[k].ecnt);
      chk($sformatf("tbl%0d_full", k),   fifo_full, 0);
      chk($sformatf("tbl%0d_ovf", k),    overflow_sticky, 0);
      drive_adv(tbl[k].v, tbl[k].a, tbl[k].d, 0);
    end

    // Three back-to-back commands, strobes 4 cycles apart, queue never full.
    s_cyc.delete(); s_cmd.delete(); saw_full = 0;
    step(1, CMD_ADDR, 32'h21, 0); step(1, CMD_ADDR, 32'h22, 0); step(1, CMD_ADDR, 32'h23, 0);
    idle(16);
    chk("b2b_n", s_cyc.size(), 3);
    if (s_cyc.size() == 3) begin
      chk("b2b_c0", s_cmd[0], 8'h21); chk("b2b_c1", s_cmd[1], 8'h22); chk("b2b_c2", s_cmd[2], 8'h23);
      chk("b2b_gap01", s_cyc[1] - s_cyc[0], 4); chk("b2b_gap12", s_cyc[2] - s_cyc[1], 4);
    end
    chk("b2b_nofull", saw_full, 0);

    // Overflow. The first command is popped one cycle after its write, so
    // writes 2..5 fill the queue. The next write lands on the second pop
    // and is still accepted. The write after it is dropped.
    s_cyc.delete(); s_cmd.delete();
    for (int i = 0; i < 7; i++) step(1, CMD_ADDR, 32'h41 + i, 0);
    chk("ovf_accept_on_pop_full", fifo_full, 1);
    chk("ovf_accept_on_pop_flag", overflow_sticky, 0);
    step(1, CMD_ADDR, 32'h48, 1);
    chk("ovf_set", overflow_sticky, 1);
    step(0, '0, '0, 1);
    chk("ovf_set_wins", overflow_sticky, 1);
    step(0, '0, '0, 0);
    chk("ovf_cleared", overflow_sticky, 0);
    idle(30);
    chk("ovf_n", s_cyc.size(), 6);
    for (int i = 0; i < 6 && i < s_cyc.size(); i++) chk("ovf_order", s_cmd[i], 8'h41 + i);

    // Hold-off after the reset command.
    s_cyc.delete(); s_cmd.delete();
    step(1, CMD_ADDR, {24'h0, RESET_CMD}, 0); step(1, CMD_ADDR, 32'h33, 0);
    idle(25);
    chk("hold_n", s_cyc.size(), 2);
    if (s_cyc.size() == 2) begin
      chk("hold_first", s_cmd[0], RESET_CMD); chk("hold_second", s_cmd[1], 8'h33);
      chk("hold_gap", s_cyc[1] - s_cyc[0], 14);
    end

    // Reset in the middle of the gap, with commands still queued.
    s_cyc.delete(); s_cmd.delete();
    step(1, CMD_ADDR, 32'h51, 0); step(1, CMD_ADDR, 32'h52, 0); step(1, CMD_ADDR, 32'h53, 0);
    for (int i = 0; i < 10 && s_cyc.size() == 0; i++) idle(1);
    chk("mid_first_strobe", s_cyc.size(), 1);
    idle(1);
    @(negedge clk); cptra_rst_b = 1'b0; #1;
    chk("mid_strobe", tb_service_cmd_valid, 0); chk("mid_cmd", tb_service_cmd, 0);
    chk("mid_count", issued_count, 0);          chk("mid_full", fifo_full, 0);
    chk("mid_busy", busy, 0);                   chk("mid_ovf", overflow_sticky, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); cptra_rst_b = 1'b1;
    model_reset(); s_cyc.delete(); s_cmd.delete();
    idle(20);
    chk("mid_no_strobe", s_cyc.size(), 0);
    chk("mid_count_after", issued_count, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      bit v, c;
      logic [31:0] a, d;
      logic [7:0] code;
      v = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 7) == 0) ? CMD_ADDR + 32'd4 : CMD_ADDR;
      case ($urandom_range(0, 7))
        0:       code = 8'h00;
        1:       code = RESET_CMD;
        default: code = 8'($urandom_range(1, 255));
      endcase
      d = {24'($urandom), code};
      c = ($urandom_range(0, 15) == 0);
      step(v, a, d, c);
    end
    idle(80);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
